// File: rtl/punjac_pkg.sv
// Shared constants, state encoding and small helpers for the sonar sample
// packer that feeds the combinational mine/rock neuron.
package punjac_pkg;

    localparam int BROJ_ZNACAJKI  = 60;
    localparam int SIRINA         = 16;
    localparam int SIRINA_UZORKA  = BROJ_ZNACAJKI * SIRINA;   // 960
    localparam int SIRINA_INDEKSA = 6;
    // Settle counter only needs to reach 14 (latency 1..15).
    localparam int SIRINA_BROJACA = 4;

    typedef enum logic [1:0] {
        PUNJENJE   = 2'd0,
        SMIRIVANJE = 2'd1,
        IZLAZ      = 2'd2
    } stanje_e;

    typedef logic [SIRINA_INDEKSA-1:0] indeks_t;

    // True when the slot index points at the final feature of a sample.
    function automatic logic je_zadnji(input indeks_t i);
        return i == indeks_t'(BROJ_ZNACAJKI - 1);
    endfunction

endpackage

// File: rtl/punjac_uzorka.sv
// punjac_uzorka: serial-to-parallel front end for the mine/rock neuron.
// Collects 60 feature words over a valid/ready stream into the 960-bit
// uzorak bus, waits LATENCIJA_NEURONA cycles for the neuron to settle,
// captures its probability and offers it with a class bit on a second
// valid/ready handshake. prekid aborts the sample in progress.
// Optional macro PUNJAC_PROVJERA_EN: words with bit 15 set are stored as
// zero and raise the sticky greska flag (cleared by reset or prekid).
module punjac_uzorka
    import punjac_pkg::*;
#(
    parameter int          LATENCIJA_NEURONA = 2,        // 1..15
    parameter logic [15:0] PRAG              = 16'h8000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SIRINA-1:0]        ulaz_podatak,
    input  logic                     ulaz_valid,
    output logic                     ulaz_ready,
    input  logic                     prekid,
    output logic [SIRINA_UZORKA-1:0] uzorak,
    input  logic [SIRINA-1:0]        neuron_izlaz,
    output logic [SIRINA-1:0]        rezultat,
    output logic                     klasa,
    output logic                     rezultat_valid,
    input  logic                     rezultat_ready,
    output logic                     greska
);

    localparam logic [SIRINA_BROJACA-1:0] ZADNJI_BROJ =
        SIRINA_BROJACA'(LATENCIJA_NEURONA - 1);

    stanje_e                   stanje_q, stanje_d;
    indeks_t                   indeks_q, indeks_d;
    logic [SIRINA_BROJACA-1:0] brojac_q, brojac_d;
    logic [SIRINA_UZORKA-1:0]  uzorak_q, uzorak_d;
    logic [SIRINA-1:0]         rezultat_q, rezultat_d;
    logic                      klasa_q, klasa_d;

    logic                      prihvat;      // word taken at this edge
    logic                      hvatanje;     // neuron output captured at this edge
    logic [SIRINA-1:0]         upis_rijec;   // value written into the slot

    // Handshake qualifiers; prekid blocks both the accept and the capture.
    always_comb begin
        prihvat  = (stanje_q == PUNJENJE) && ulaz_valid && !prekid;
        hvatanje = (stanje_q == SMIRIVANJE) && (brojac_q == ZADNJI_BROJ) && !prekid;
    end

`ifdef PUNJAC_PROVJERA_EN
    logic greska_q, greska_d;

    // Negative / overrange words are replaced by zero before packing.
    always_comb begin
        upis_rijec = ulaz_podatak[SIRINA-1] ? '0 : ulaz_podatak;
    end

    // Sticky error flag: set by a bad accepted word, cleared by prekid.
    always_comb begin
        greska_d = greska_q;
        if (prekid)
            greska_d = 1'b0;
        else if (prihvat && ulaz_podatak[SIRINA-1])
            greska_d = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) greska_q <= 1'b0;
        else        greska_q <= greska_d;
    end

    assign greska = greska_q;
`else
    // Words are packed exactly as received.
    always_comb begin
        upis_rijec = ulaz_podatak;
    end

    assign greska = 1'b0;
`endif

    // Next-state logic; prekid overrides every handshake.
    always_comb begin
        stanje_d = stanje_q;
        if (prekid) begin
            stanje_d = PUNJENJE;
        end else begin
            case (stanje_q)
                PUNJENJE:   if (prihvat && je_zadnji(indeks_q)) stanje_d = SMIRIVANJE;
                SMIRIVANJE: if (hvatanje)                       stanje_d = IZLAZ;
                IZLAZ:      if (rezultat_ready)                 stanje_d = PUNJENJE;
                default:                                        stanje_d = PUNJENJE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stanje_q <= PUNJENJE;
        else        stanje_q <= stanje_d;
    end

    // Handshake outputs are pure decodes of the state flops.
    always_comb begin
        ulaz_ready     = (stanje_q == PUNJENJE);
        rezultat_valid = (stanje_q == IZLAZ);
    end

    // Slot index: advances per accepted word, back to 0 after slot 59 or on abort.
    always_comb begin
        indeks_d = indeks_q;
        if (prekid)
            indeks_d = '0;
        else if (prihvat)
            indeks_d = je_zadnji(indeks_q) ? '0 : indeks_q + 1'b1;
    end

    // Settle counter: runs only in SMIRIVANJE, idles at 0 elsewhere.
    always_comb begin
        brojac_d = '0;
        if (stanje_q == SMIRIVANJE && !prekid && !hvatanje)
            brojac_d = brojac_q + 1'b1;
    end

    // Pack register: only the addressed slot changes; nothing is ever cleared
    // except by reset, so uzorak stays frozen outside PUNJENJE.
    always_comb begin
        uzorak_d = uzorak_q;
        if (prihvat) begin
            for (int k = 0; k < BROJ_ZNACAJKI; k++) begin
                if (indeks_q == SIRINA_INDEKSA'(k))
                    uzorak_d[k*SIRINA +: SIRINA] = upis_rijec;
            end
        end
    end

    // Result capture on the last settle cycle; otherwise hold.
    always_comb begin
        rezultat_d = rezultat_q;
        klasa_d    = klasa_q;
        if (hvatanje) begin
            rezultat_d = neuron_izlaz;
            klasa_d    = (neuron_izlaz >= PRAG);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            indeks_q   <= '0;
            brojac_q   <= '0;
            uzorak_q   <= '0;
            rezultat_q <= '0;
            klasa_q    <= 1'b0;
        end else begin
            indeks_q   <= indeks_d;
            brojac_q   <= brojac_d;
            uzorak_q   <= uzorak_d;
            rezultat_q <= rezultat_d;
            klasa_q    <= klasa_d;
        end
    end

    assign uzorak   = uzorak_q;
    assign rezultat = rezultat_q;
    assign klasa    = klasa_q;

endmodule

// File: tb/tb_punjac_uzorka.sv
// Self-checking bench for punjac_uzorka: random stimulus against a slot-array
// reference model. Honours PUNJAC_PROVJERA_EN the same way as the design.
module tb_punjac_uzorka;
    import punjac_pkg::*;

    localparam int LAT = 2;
`ifdef PUNJAC_PROVJERA_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  ulaz_podatak;
    logic         ulaz_valid;
    logic         ulaz_ready;
    logic         prekid;
    logic [959:0] uzorak;
    logic [15:0]  neuron_izlaz;
    logic [15:0]  rezultat;
    logic         klasa;
    logic         rezultat_valid;
    logic         rezultat_ready;
    logic         greska;

    bit           hash_mode;
    logic [15:0]  neuron_const;
    logic [15:0]  hash_v;

    int checks = 0;
    int errors = 0;

    // reference model
    logic [15:0] m_slot [60];
    int          m_idx;
    bit          m_greska;
    logic [15:0] m_rez;

    always #5 clk = ~clk;

    // stand-in neuron: a function of the whole bus so frozen/wrong slots show up
    always_comb begin
        hash_v = 16'h5A5A;
        for (int k = 0; k < 60; k++)
            hash_v = {hash_v[14:0], hash_v[15]} ^ uzorak[k*16 +: 16];
    end
    assign neuron_izlaz = hash_mode ? hash_v : neuron_const;

    punjac_uzorka #(.LATENCIJA_NEURONA(LAT), .PRAG(16'h8000)) dut (
        .clk(clk), .rst_n(rst_n),
        .ulaz_podatak(ulaz_podatak), .ulaz_valid(ulaz_valid), .ulaz_ready(ulaz_ready),
        .prekid(prekid), .uzorak(uzorak), .neuron_izlaz(neuron_izlaz),
        .rezultat(rezultat), .klasa(klasa), .rezultat_valid(rezultat_valid),
        .rezultat_ready(rezultat_ready), .greska(greska)
    );

    function automatic logic [15:0] m_stored(input logic [15:0] d);
        return (CHK && d[15]) ? 16'h0000 : d;
    endfunction

    function automatic logic [959:0] m_uzorak();
        logic [959:0] v;
        for (int k = 0; k < 60; k++) v[k*16 +: 16] = m_slot[k];
        return v;
    endfunction

    function automatic logic [15:0] m_neuron();
        logic [15:0] h;
        h = 16'h5A5A;
        for (int k = 0; k < 60; k++) h = {h[14:0], h[15]} ^ m_slot[k];
        return hash_mode ? h : neuron_const;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 60; k++) m_slot[k] = 16'h0000;
        m_idx    = 0;
        m_greska = 1'b0;
        m_rez    = 16'h0000;
    endfunction

    // Presents words until n are accepted; mode 0: 0x0100+slot, 1: random,
    // 2: random with bit 15 clear except slot 7 = 0x8123. Returns at the
    // negedge after the final accepting edge with valid dropped.
    task automatic feed(input int n, input int pct, input int mode,
                        output int acc, output bit tout);
        int          cyc;
        logic [15:0] d;
        acc = 0; cyc = 0; tout = 1'b0;
        while (acc < n) begin
            @(negedge clk);
            if (cyc > 4000) begin tout = 1'b1; break; end
            cyc++;
            case (mode)
                0:       d = 16'h0100 + 16'(m_idx);
                1:       d = 16'($urandom);
                default: d = (m_idx == 7) ? 16'h8123 : {1'b0, 15'($urandom)};
            endcase
            ulaz_podatak = d;
            ulaz_valid   = ($urandom_range(99) < pct);
            if (ulaz_valid && ulaz_ready) begin
                m_slot[m_idx] = m_stored(d);
                if (CHK && d[15]) m_greska = 1'b1;
                m_idx = (m_idx == 59) ? 0 : m_idx + 1;
                acc++;
            end
        end
        @(negedge clk);
        ulaz_valid = 1'b0;
    endtask

    // Counts negedges until rezultat_valid rises (bounded).
    task automatic wait_capture(output int lat);
        lat = 0;
        while (!rezultat_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ulaz_valid = 1'b0; ulaz_podatak = '0; prekid = 1'b0;
        rezultat_ready = 1'b0; hash_mode = 1'b0; neuron_const = 16'h0000;
        m_reset();
        repeat (2) @(negedge clk);
        checks++; if (ulaz_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ulaz_ready); end
        checks++; if (rezultat_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rezultat_valid); end
        checks++; if (uzorak !== '0) begin errors++; $display("FAIL reset_uzorak not zero"); end
        checks++; if ({rezultat, klasa, greska} !== 18'h0) begin errors++; $display("FAIL reset_rez got %h/%b/%b exp 0", rezultat, klasa, greska); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int acc, lat; bit tout;
        hash_mode = 1'b0; neuron_const = 16'h9000; rezultat_ready = 1'b1;
        feed(60, 100, 0, acc, tout);
        checks++; if (tout || acc != 60) begin errors++; $display("FAIL basic_feed got %0d accepts exp 60", acc); end
        checks++; if (ulaz_ready !== 1'b0) begin errors++; $display("FAIL basic_settle_ready got %b exp 0", ulaz_ready); end
        wait_capture(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT); end
        m_rez = m_neuron();
        checks++; if (uzorak[15:0] !== 16'h0100 || uzorak[959:944] !== 16'h013B) begin errors++; $display("FAIL basic_ends got %h/%h exp 0100/013b", uzorak[15:0], uzorak[959:944]); end
        checks++; if (uzorak !== m_uzorak()) begin errors++; $display("FAIL basic_uzorak differs from model"); end
        checks++; if (rezultat !== 16'h9000 || klasa !== 1'b1) begin errors++; $display("FAIL basic_rez got %h/%b exp 9000/1", rezultat, klasa); end
        @(negedge clk);
        checks++; if (ulaz_ready !== 1'b1 || rezultat_valid !== 1'b0) begin errors++; $display("FAIL basic_taken got rdy %b vld %b exp 1/0", ulaz_ready, rezultat_valid); end
    endtask

    task automatic test_backpressure();
        int acc, lat; bit tout;
        hash_mode = 1'b0; neuron_const = 16'h7FFF; rezultat_ready = 1'b0;
        feed(60, 50, 1, acc, tout);
        checks++; if (tout || acc != 60) begin errors++; $display("FAIL bp_feed got %0d accepts exp 60", acc); end
        wait_capture(lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, LAT); end
        m_rez = 16'h7FFF;
        for (int i = 0; i < 10; i++) begin
            ulaz_valid = ($urandom_range(1) == 1); ulaz_podatak = 16'($urandom);
            checks++;
            if (rezultat !== m_rez || klasa !== 1'b0 || ulaz_ready !== 1'b0 ||
                rezultat_valid !== 1'b1 || uzorak !== m_uzorak()) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got rez %h kl %b rdy %b vld %b exp 7fff/0/0/1", i, rezultat, klasa, ulaz_ready, rezultat_valid);
            end
            @(negedge clk);
        end
        ulaz_valid = 1'b0;
        checks++; if (greska !== m_greska) begin errors++; $display("FAIL bp_greska got %b exp %b", greska, m_greska); end
        rezultat_ready = 1'b1;
        @(negedge clk);
        checks++; if (ulaz_ready !== 1'b1 || rezultat_valid !== 1'b0) begin errors++; $display("FAIL bp_taken got rdy %b vld %b exp 1/0", ulaz_ready, rezultat_valid); end
    endtask

    task automatic test_abort();
        int acc, lat; bit tout, saw_vld;
        hash_mode = 1'b1; rezultat_ready = 1'b0;
        feed(30, 100, 1, acc, tout);
        // abort together with a valid word
        ulaz_valid = 1'b1; ulaz_podatak = 16'h1234; prekid = 1'b1;
        m_idx = 0; m_greska = 1'b0;
        @(negedge clk);
        prekid = 1'b0; ulaz_valid = 1'b0;
        checks++; if (uzorak !== m_uzorak() || ulaz_ready !== 1'b1 || rezultat_valid !== 1'b0) begin errors++; $display("FAIL abort_fill got rdy %b vld %b uzorak_ok %b exp 1/0/1", ulaz_ready, rezultat_valid, uzorak === m_uzorak()); end
        checks++; if (greska !== 1'b0) begin errors++; $display("FAIL abort_greska got %b exp 0", greska); end
        feed(1, 100, 1, acc, tout);
        checks++; if (uzorak[15:0] !== m_slot[0] || uzorak !== m_uzorak()) begin errors++; $display("FAIL abort_slot0 got %h exp %h", uzorak[15:0], m_slot[0]); end
        feed(59, 100, 1, acc, tout);
        checks++; if (tout || acc != 59) begin errors++; $display("FAIL abort_feed got %0d accepts exp 59", acc); end
        wait_capture(lat);
        m_rez = m_neuron();
        checks++; if (lat != LAT || rezultat !== m_rez || klasa !== (m_rez >= 16'h8000)) begin errors++; $display("FAIL abort_rez got %h/%b lat %0d exp %h lat %0d", rezultat, klasa, lat, m_rez, LAT); end
        // abort while the result is pending: valid drops, result kept
        prekid = 1'b1; m_idx = 0; m_greska = 1'b0;
        @(negedge clk);
        prekid = 1'b0;
        checks++; if (rezultat_valid !== 1'b0 || ulaz_ready !== 1'b1 || rezultat !== m_rez) begin errors++; $display("FAIL abort_izlaz got vld %b rdy %b rez %h exp 0/1/%h", rezultat_valid, ulaz_ready, rezultat, m_rez); end
        // abort during settle: no capture ever happens
        feed(60, 100, 1, acc, tout);
        prekid = 1'b1; m_idx = 0; m_greska = 1'b0;
        @(negedge clk);
        prekid = 1'b0;
        saw_vld = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (rezultat_valid) saw_vld = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_vld || rezultat !== m_rez || ulaz_ready !== 1'b1) begin errors++; $display("FAIL abort_settle got vld_seen %b rez %h exp 0/%h", saw_vld, rezultat, m_rez); end
        rezultat_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int acc, lat; bit tout;
        hash_mode = 1'b1; rezultat_ready = 1'b1;
        feed(45, 100, 1, acc, tout);
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (uzorak !== '0 || ulaz_ready !== 1'b1 || rezultat_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got rdy %b vld %b uzorak_zero %b exp 1/0/1", ulaz_ready, rezultat_valid, uzorak === '0); end
        checks++; if (rezultat !== 16'h0 || greska !== 1'b0) begin errors++; $display("FAIL rstmid_rez got %h/%b exp 0/0", rezultat, greska); end
        @(negedge clk);
        rst_n = 1'b1;
        feed(60, 70, 1, acc, tout);
        checks++; if (tout || acc != 60) begin errors++; $display("FAIL rstmid_feed got %0d accepts exp 60", acc); end
        wait_capture(lat);
        m_rez = m_neuron();
        checks++; if (lat != LAT || rezultat !== m_rez || klasa !== (m_rez >= 16'h8000) || uzorak !== m_uzorak()) begin errors++; $display("FAIL rstmid_rez2 got %h/%b lat %0d exp %h lat %0d", rezultat, klasa, lat, m_rez, LAT); end
        checks++; if (greska !== m_greska) begin errors++; $display("FAIL rstmid_greska got %b exp %b", greska, m_greska); end
        @(negedge clk);
    endtask

    task automatic test_greska();
        int acc, lat; bit tout;
        hash_mode = 1'b1; rezultat_ready = 1'b0;
        prekid = 1'b1; m_idx = 0; m_greska = 1'b0;
        @(negedge clk);
        prekid = 1'b0;
        feed(60, 100, 2, acc, tout);
        checks++; if (uzorak[127:112] !== (CHK ? 16'h0000 : 16'h8123) || uzorak !== m_uzorak()) begin errors++; $display("FAIL chk_slot7 got %h exp %h", uzorak[127:112], CHK ? 16'h0000 : 16'h8123); end
        checks++; if (greska !== CHK) begin errors++; $display("FAIL chk_greska got %b exp %b", greska, CHK); end
        wait_capture(lat);
        repeat (3) @(negedge clk);
        checks++; if (greska !== m_greska || rezultat_valid !== 1'b1) begin errors++; $display("FAIL chk_sticky got %b vld %b exp %b/1", greska, rezultat_valid, m_greska); end
        prekid = 1'b1; m_greska = 1'b0; m_idx = 0;
        @(negedge clk);
        prekid = 1'b0;
        checks++; if (greska !== 1'b0) begin errors++; $display("FAIL chk_clear got %b exp 0", greska); end
        rezultat_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_greska();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/punjac_uzorka.md
# punjac_uzorka

Sequential front end for the combinational mine/rock neuron. Accepts 60 sonar features one 16-bit word at a time over a valid/ready stream and packs them into the 960-bit parallel `uzorak` bus that drives the neuron. Waits a fixed settle time, captures the neuron's 16-bit probability, and returns it over a second valid/ready handshake with a mine/rock class bit. The neuron is instantiated beside this block by the integrating top, not inside it.

## Interface
- `BROJ_ZNACAJKI`, 60: features per sample.
- `SIRINA`, 16: bits per feature and per result.
- `LATENCIJA_NEURONA`, 2: settle cycles before capture, legal range 1..15.
- `PRAG`, 16'h8000: class threshold, unsigned compare.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ulaz_podatak` in 16: feature word, unsigned.
- `ulaz_valid` in 1: feature word valid.
- `ulaz_ready` out 1: block accepts a word.
- `prekid` in 1: synchronous abort of the current sample.
- `uzorak` out 960: packed sample to the neuron; feature k sits at [16k+15:16k].
- `neuron_izlaz` in 16: neuron probability output, combinational from `uzorak`.
- `rezultat` out 16: captured probability.
- `klasa` out 1: 1 when `rezultat >= PRAG` (mine).
- `rezultat_valid` out 1: result available.
- `rezultat_ready` in 1: consumer takes the result.
- `greska` out 1: sticky input-format error; see Configuration.

## Operation
- FSM states:
  - PUNJENJE, the reset state: `ulaz_ready`=1.
  - SMIRIVANJE: `ulaz_ready`=0. A settle counter runs.
  - IZLAZ: `rezultat_valid`=1.
- PUNJENJE:
  - A word is accepted on a clock edge where `ulaz_valid && ulaz_ready`.
  - The accepted word is written to slot `indeks`, then `indeks` increments.
  - The first word after entry goes to slot 0, at [15:0].
  - Accepting slot 59 moves the FSM to SMIRIVANJE and clears `indeks` to 0.
- SMIRIVANJE:
  - `uzorak` is frozen.
  - The counter counts `LATENCIJA_NEURONA` cycles.
  - On the final cycle, `neuron_izlaz` is registered into `rezultat`, `klasa` is registered from the same value, and the FSM moves to IZLAZ.
- IZLAZ:
  - `rezultat`, `klasa` and `uzorak` hold stable while `rezultat_ready`=0.
  - On `rezultat_valid && rezultat_ready` the FSM returns to PUNJENJE.
- `uzorak` is never cleared between samples; every slot is overwritten by the next sample.
- `prekid`=1 has priority over every handshake in the same cycle:
  - Next state is PUNJENJE, `indeks` goes to 0 and `rezultat_valid` drops.
  - Any word presented in that cycle is not accepted.
  - `uzorak` keeps its contents, and `rezultat` keeps its last value.
- `indeks` is 6 bits wide and never exceeds 59. There is no wrap-around past 59.
- Reset values:
  - State PUNJENJE, `ulaz_ready`=1.
  - `uzorak`, `rezultat` and `indeks` all 0.
  - `klasa`=0, `rezultat_valid`=0, `greska`=0.
- Reset asserted mid-operation returns everything to these values immediately. No partial sample survives.

## Timing
- Word accepted at edge E: the matching slot of `uzorak` shows it after E.
- Last word accepted at edge E0: capture happens at edge E0+`LATENCIJA_NEURONA`, and `rezultat_valid`=1 from that edge.
- Result taken at edge R: `ulaz_ready`=1 after R. The first word of the next sample can be accepted at edge R+1.
- Minimum period per sample: 60 + `LATENCIJA_NEURONA` + 1 cycles.
- `ulaz_ready` depends only on state, never combinationally on `ulaz_valid`. All outputs are registered.

## Configuration
- Macro `PUNJAC_PROVJERA_EN`.
- Defined:
  - An accepted word with bit 15 set (a negative or overrange sample) is stored as 16'h0000.
  - `greska` is set to 1.
  - `greska` clears only on reset or on `prekid`.
- Undefined:
  - Words are stored unmodified.
  - `greska` is tied to 0, and the check logic is not synthesised.

## Structure
- Package `punjac_pkg` holds:
  - `BROJ_ZNACAJKI`, `SIRINA`, and `SIRINA_UZORKA` = 960.
  - The state enum: PUNJENJE, SMIRIVANJE, IZLAZ.
  - The index width: 6.
- No sub-module. The FSM, settle counter and pack register fit in one module.

## Test plan
- Basic sample:
  - Stimulus: feed words k=0..59 with value 16'h0100+k and valid held high; `neuron_izlaz` driven to 16'h9000; `rezultat_ready`=1.
  - Response: `uzorak[15:0]`=16'h0100 and `uzorak[959:944]`=16'h013B.
  - Response: `rezultat_valid` rises 2 cycles after the 60th accept, with `rezultat`=16'h9000 and `klasa`=1.
- Backpressure on input and output:
  - Stimulus: toggle `ulaz_valid` randomly; hold `rezultat_ready`=0 for 10 cycles; `neuron_izlaz`=16'h7FFF.
  - Response: exactly 60 accepts; `rezultat`=16'h7FFF and `klasa`=0, both stable for all 10 cycles; `ulaz_ready`=0 throughout.
- Abort:
  - Stimulus: assert `prekid` after 30 words, in the same cycle as a valid word.
  - Response: that word is not accepted; the next word lands in slot 0; `rezultat_valid` stays 0.
- Reset mid-sample:
  - Stimulus: drop `rst_n` after 45 words.
  - Response: `uzorak`=0, `ulaz_ready`=1, `rezultat_valid`=0.
  - Response: a fresh run of 60 words completes normally.
- `PUNJAC_PROVJERA_EN` defined:
  - Stimulus: word 7 = 16'h8123.
  - Response: slot 7 = 16'h0000 and `greska`=1, which stays 1 until `prekid`.
  - Same stimulus with the macro undefined: slot 7 = 16'h8123 and `greska`=0.
